ace_req_arbiter: RTL and testbench

Round-robin arbiter that lets several cache controllers share one ACE controller. Each requester presents a read, writeback or invalidate request with an address. The arbiter grants one requester at a time, latches that request, and drives it to the ACE controller. It returns `ace_ready` to the granted requester only, and releases the grant on completion. It sits between the per-core cache controllers and the single ACE controller instance.

---
 rtl/ace_req_arbiter.sv | 146 ++++++++++++++
 tb/tb_ace_req_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ace_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ace_req_arbiter
// Purpose  : Round-robin arbiter letting NUM_REQ cache controllers share a
//            single ACE controller. One request is granted at a time; its
//            type and address are latched and held on the ACE side until the
//            ACE controller signals completion, which is reflected back to
//            the granted requester only. A watchdog flags a stuck transaction.
// Ports    : clk, reset (async, active-low)
//            req_read/req_write/req_invalid [NUM_REQ]   requester requests
//            req_addr [NUM_REQ*ADDR_WIDTH]              packed addresses
//            req_ready [NUM_REQ]                        completion strobe
//            ace_read_req/ace_write_req/ace_invalid_req ACE request type
//            ace_addr [ADDR_WIDTH]                      latched address
//            ace_ready                                  ACE completion
//            grant_id [IDW]                             current/last grant
//            arb_busy                                   transaction in flight
//            timeout_err                                sticky watchdog flag
// Revision : 1.0 - initial release
// ============================================================================
module ace_req_arbiter #(
  parameter  int NUM_REQ        = 2,
  parameter  int ADDR_WIDTH     = 32,
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int IDW            = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_read,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ-1:0]            req_invalid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          ace_read_req,
  output logic                          ace_write_req,
  output logic                          ace_invalid_req,
  output logic [ADDR_WIDTH-1:0]         ace_addr,
  input  logic                          ace_ready,
  output logic [IDW-1:0]                grant_id,
  output logic                          arb_busy,
  output logic                          timeout_err
);

  // Watchdog counter only needs to reach TIMEOUT_CYCLES, where it saturates.
  localparam bit             WD_EN   = (TIMEOUT_CYCLES != 0);
  localparam int             WDW     = WD_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WDW-1:0] WD_MAX  = WDW'(TIMEOUT_CYCLES);
  localparam logic [WDW-1:0] WD_LAST = WD_EN ? WDW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic [WDW-1:0]   wd_cnt;

  logic [NUM_REQ-1:0] active;
  logic               found;
  logic [IDW-1:0]     sel;
  logic [IDW:0]       cand;
  logic [IDW-1:0]     next_ptr;

  assign active = req_read | req_write | req_invalid;

  // Search rr_ptr, rr_ptr+1, ... with an explicit subtract-wrap so that
  // non-power-of-two NUM_REQ never indexes past the last requester.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NUM_REQ)) begin
        cand = cand - (IDW+1)'(NUM_REQ);
      end
      if (!found && active[cand[IDW-1:0]]) begin
        found = 1'b1;
        sel   = cand[IDW-1:0];
      end
    end
  end

  assign next_ptr = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

  // Completion is passed straight through to the granted requester only.
  always_comb begin
    req_ready = '0;
    if (state == BUSY && ace_ready) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      grant_id        <= '0;
      ace_read_req    <= 1'b0;
      ace_write_req   <= 1'b0;
      ace_invalid_req <= 1'b0;
      ace_addr        <= '0;
      arb_busy        <= 1'b0;
      wd_cnt          <= '0;
      timeout_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state    <= BUSY;
            arb_busy <= 1'b1;
            grant_id <= sel;
            ace_addr <= req_addr[sel*ADDR_WIDTH +: ADDR_WIDTH];
            // Multiple types at once: write beats invalidate beats read.
            ace_write_req   <= req_write[sel];
            ace_invalid_req <= !req_write[sel] && req_invalid[sel];
            ace_read_req    <= !req_write[sel] && !req_invalid[sel] && req_read[sel];
            wd_cnt          <= '0;
          end
        end
        BUSY: begin
          if (ace_ready) begin
            state           <= IDLE;
            arb_busy        <= 1'b0;
            ace_read_req    <= 1'b0;
            ace_write_req   <= 1'b0;
            ace_invalid_req <= 1'b0;
            rr_ptr          <= next_ptr;
          end else begin
            if (wd_cnt != WD_MAX) begin
              wd_cnt <= wd_cnt + 1'b1;
            end
            // wd_cnt == WD_LAST means this is the TIMEOUT_CYCLES-th stalled cycle.
            if (WD_EN && wd_cnt == WD_LAST) begin
              timeout_err <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ace_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ace_req_arbiter
// Purpose  : Directed self-checking bench for ace_req_arbiter. Instance u_a
//            is 2 requesters with a 4-cycle watchdog; u_b is 3 requesters
//            with the watchdog disabled.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ace_req_arbiter;

  logic clk;
  logic reset;

  // u_a : NUM_REQ=2, TIMEOUT_CYCLES=4
  logic [1:0]  a_rd, a_wr, a_inv, a_req_ready;
  logic [63:0] a_addr;
  logic        a_ace_rd, a_ace_wr, a_ace_inv, a_ace_ready, a_busy, a_to;
  logic [31:0] a_ace_addr;
  logic [0:0]  a_gid;

  // u_b : NUM_REQ=3, TIMEOUT_CYCLES=0
  logic [2:0]  b_rd, b_wr, b_inv, b_req_ready;
  logic [95:0] b_addr;
  logic        b_ace_rd, b_ace_wr, b_ace_inv, b_ace_ready, b_busy, b_to;
  logic [31:0] b_ace_addr;
  logic [1:0]  b_gid;

  int checks = 0;
  int errors = 0;

  ace_req_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) u_a (
    .clk(clk), .reset(reset),
    .req_read(a_rd), .req_write(a_wr), .req_invalid(a_inv), .req_addr(a_addr),
    .req_ready(a_req_ready),
    .ace_read_req(a_ace_rd), .ace_write_req(a_ace_wr), .ace_invalid_req(a_ace_inv),
    .ace_addr(a_ace_addr), .ace_ready(a_ace_ready),
    .grant_id(a_gid), .arb_busy(a_busy), .timeout_err(a_to)
  );

  ace_req_arbiter #(.NUM_REQ(3), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(0)) u_b (
    .clk(clk), .reset(reset),
    .req_read(b_rd), .req_write(b_wr), .req_invalid(b_inv), .req_addr(b_addr),
    .req_ready(b_req_ready),
    .ace_read_req(b_ace_rd), .ace_write_req(b_ace_wr), .ace_invalid_req(b_ace_inv),
    .ace_addr(b_ace_addr), .ace_ready(b_ace_ready),
    .grant_id(b_gid), .arb_busy(b_busy), .timeout_err(b_to)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge; inputs are then driven 2 time units after it.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Pack of all u_a request outputs: {rd,wr,inv,busy}
  function automatic logic [3:0] a_flags();
    return {a_ace_rd, a_ace_wr, a_ace_inv, a_busy};
  endfunction

  function automatic logic [3:0] b_flags();
    return {b_ace_rd, b_ace_wr, b_ace_inv, b_busy};
  endfunction

  initial begin
    reset = 1'b0;
    a_rd = '0; a_wr = '0; a_inv = '0; a_addr = '0; a_ace_ready = 1'b0;
    b_rd = '0; b_wr = '0; b_inv = '0; b_addr = '0; b_ace_ready = 1'b0;
    repeat (2) step();

    // ---------------- reset values ----------------
    chk("a_reset_flags", a_flags(), 4'b0000);
    chk("a_reset_addr", a_ace_addr, 32'h0);
    chk("a_reset_gid", a_gid, 1'b0);
    chk("a_reset_ready", a_req_ready, 2'b00);
    chk("a_reset_to", a_to, 1'b0);
    chk("b_reset_flags", b_flags(), 4'b0000);
    chk("b_reset_gid", b_gid, 2'd0);

    reset = 1'b1;

    // ---------------- u_b round robin, 3 requesters ----------------
    b_wr = 3'b111;
    b_ace_ready = 1'b1;
    b_addr = {32'h3000_0002, 32'h3000_0001, 32'h3000_0000};
    for (int t = 0; t < 4; t++) begin
      int id;
      id = t % 3;
      step(); #1;
      chk("b_rr_gid", b_gid, 64'(id));
      chk("b_rr_flags", b_flags(), 4'b0101);
      chk("b_rr_addr", b_ace_addr, 64'(32'h3000_0000 + id));
      chk("b_rr_ready", b_req_ready, 64'(3'b001 << id));
      step(); #1;
      chk("b_rr_idle_flags", b_flags(), 4'b0000);
      chk("b_rr_idle_ready", b_req_ready, 3'b000);
    end
    // After grant 0 the pointer is at 1; hold BUSY with watchdog disabled.
    b_ace_ready = 1'b0;
    step(); #1;
    chk("b_wd_gid", b_gid, 2'd1);
    repeat (6) step();
    chk("b_wd_busy", b_busy, 1'b1);
    chk("b_wd_to_disabled", b_to, 1'b0);
    chk("b_wd_noready", b_req_ready, 3'b000);
    b_ace_ready = 1'b1; #1;
    chk("b_wd_ack", b_req_ready, 3'b010);
    step();
    b_wr = '0; b_ace_ready = 1'b0;
    step(); #1;
    chk("b_final_idle", b_flags(), 4'b0000);

    // ---------------- u_a single request ----------------
    a_rd = 2'b10;
    a_addr = {32'h0000_1000, 32'h2222_0000};
    step(); #1;
    chk("a_single_flags", a_flags(), 4'b1001);
    chk("a_single_addr", a_ace_addr, 32'h0000_1000);
    chk("a_single_gid", a_gid, 1'b1);
    chk("a_single_noready", a_req_ready, 2'b00);
    step(); step();
    a_ace_ready = 1'b1; #1;
    chk("a_single_ready", a_req_ready, 2'b10);
    step();
    a_ace_ready = 1'b0; a_rd = 2'b00; #1;
    chk("a_single_done", a_flags(), 4'b0000);
    chk("a_single_done_ready", a_req_ready, 2'b00);
    chk("a_single_gid_kept", a_gid, 1'b1);
    a_ace_ready = 1'b1; #1;
    chk("a_idle_ignores_ready", a_req_ready, 2'b00);
    a_ace_ready = 1'b0;

    // ---------------- u_a type priority and hold ----------------
    a_rd = 2'b01; a_wr = 2'b01;
    step(); #1;
    chk("a_prio_flags", a_flags(), 4'b0101);
    chk("a_prio_gid", a_gid, 1'b0);
    chk("a_prio_addr", a_ace_addr, 32'h2222_0000);
    a_rd = 2'b00; a_wr = 2'b00;
    step(); #1;
    chk("a_hold_flags", a_flags(), 4'b0101);
    // ---------------- back-to-back re-request ----------------
    a_ace_ready = 1'b1; a_rd = 2'b01; #1;
    chk("a_b2b_ready", a_req_ready, 2'b01);
    step();
    a_ace_ready = 1'b0; #1;
    chk("a_b2b_m1_idle", a_flags(), 4'b0000);
    step(); #1;
    chk("a_b2b_m2_flags", a_flags(), 4'b1001);
    chk("a_b2b_m2_gid", a_gid, 1'b0);

    // ---------------- u_a watchdog (4 cycles) ----------------
    chk("a_wd_c1", a_to, 1'b0);
    step(); step(); step(); #1;
    chk("a_wd_c4", a_to, 1'b0);
    step(); #1;
    chk("a_wd_set", a_to, 1'b1);
    chk("a_wd_still_busy", a_busy, 1'b1);
    a_ace_ready = 1'b1; #1;
    chk("a_wd_ack", a_req_ready, 2'b01);
    step();
    a_ace_ready = 1'b0; a_rd = 2'b00; #1;
    chk("a_wd_sticky", a_to, 1'b1);
    chk("a_wd_idle", a_busy, 1'b0);

    // ---------------- u_a invalidate beats read ----------------
    a_inv = 2'b10; a_rd = 2'b10;
    a_addr = {32'h4444_0000, 32'h2222_0000};
    step(); #1;
    chk("a_inv_flags", a_flags(), 4'b0011);
    chk("a_inv_gid", a_gid, 1'b1);
    chk("a_inv_addr", a_ace_addr, 32'h4444_0000);
    a_ace_ready = 1'b1; #1;
    chk("a_inv_ready", a_req_ready, 2'b10);
    step();
    a_ace_ready = 1'b0; a_inv = '0; a_rd = '0;

    // ---------------- u_a mid-transaction reset ----------------
    a_wr = 2'b10;
    step(); #1;
    chk("a_rst_pre_gid", a_gid, 1'b1);
    chk("a_rst_pre_flags", a_flags(), 4'b0101);
    a_ace_ready = 1'b1;
    reset = 1'b0; #1;
    chk("a_rst_flags", a_flags(), 4'b0000);
    chk("a_rst_ready", a_req_ready, 2'b00);
    chk("a_rst_addr", a_ace_addr, 32'h0);
    chk("a_rst_gid", a_gid, 1'b0);
    chk("a_rst_to", a_to, 1'b0);
    step();
    a_ace_ready = 1'b0; a_wr = 2'b11;
    reset = 1'b1;
    step(); #1;
    chk("a_post_rst_gid", a_gid, 1'b0);
    chk("a_post_rst_flags", a_flags(), 4'b0101);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
